// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states, verdict codes and the cycle counter width.
package mem_write_checker_pkg;

  localparam int CYCLES_W = 32;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } checker_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISMATCH = 2'd1,
    ORDER    = 2'd2,
    TIMEOUT  = 2'd3
  } fail_code_t;

endpackage

// File: rtl/mem_write_checker_if.sv
// Core data-memory write port as seen by the checker; the core side drives, the checker only observes.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);

endinterface

// File: rtl/mem_write_checker_reset_sequencer.sv
// Holds the core in reset for RESET_CYCLES edges after reset falls, then releases it for good.
// o_dut_reset is registered; o_release is a one-cycle strobe marking the edge on which o_dut_reset falls.
module reset_sequencer #(
  parameter int RESET_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic o_dut_reset,
  output logic o_release
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_dut_reset;
  logic          w_last;

  assign w_last      = (r_cnt == CW'(RESET_CYCLES - 1));
  // Decoded ahead of the edge so the checker enters RUN on the same edge the core leaves reset.
  assign o_release   = r_dut_reset & ~reset & w_last;
  assign o_dut_reset = r_dut_reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_dut_reset <= 1'b1;
    end else if (r_dut_reset) begin
      if (w_last) begin
        r_dut_reset <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// End-of-test checker: sequences core reset, then matches core memory writes against an expected table.
// Verdict one edge after the deciding write; the write port is observe-only and never stalled.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int                  RESET_CYCLES   = 2,
  parameter logic [CYCLES_W-1:0] TIMEOUT_CYCLES = 10000,
  parameter int                  NUM_CHECKS     = 1,
  parameter int                  ADDR_W         = 32,
  parameter int                  DATA_W         = 32,
  parameter bit                  STRICT_ORDER   = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHECKS*ADDR_W-1:0]       check_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0]       check_data,
  mem_write_checker_if.slave                 wr,
  output logic                               dut_reset,
  output logic                               running,
  output logic                               done,
  output logic                               pass,
  output logic                               fail,
  output fail_code_t                         fail_code,
  output logic [$clog2(NUM_CHECKS+1)-1:0]    matched,
  output logic [CYCLES_W-1:0]                cycles
);

  localparam int MW = $clog2(NUM_CHECKS + 1);

  checker_state_t        r_state;
  fail_code_t            r_fail_code;
  logic                  r_running;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;
  logic [MW-1:0]         r_matched;
  logic [CYCLES_W-1:0]   r_cycles;
  logic [NUM_CHECKS-1:0] r_bitmap;

  logic                  w_release;
  logic [NUM_CHECKS-1:0] w_addr_eq;
  logic [NUM_CHECKS-1:0] w_data_eq;
  logic [NUM_CHECKS-1:0] w_is_exp;
  logic [NUM_CHECKS-1:0] w_after;
  logic [NUM_CHECKS-1:0] w_cand;
  logic [NUM_CHECKS-1:0] w_sel;
  logic [CYCLES_W-1:0]   w_cycles_nxt;
  logic                  w_hit;
  logic                  w_data_ok;
  logic                  w_match;
  logic                  w_final;
  logic                  w_mismatch;
  logic                  w_order;
  logic                  w_timeout;

  reset_sequencer #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_reset_sequencer (
    .clk         (clk),
    .reset       (reset),
    .o_dut_reset (dut_reset),
    .o_release   (w_release)
  );

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_cmp
    assign w_addr_eq[gi] = (wr.DataAdr   == check_addr[gi*ADDR_W +: ADDR_W]);
    assign w_data_eq[gi] = (wr.WriteData == check_data[gi*DATA_W +: DATA_W]);
    assign w_is_exp[gi]  = (r_matched == MW'(gi));
    assign w_after[gi]   = (r_matched <  MW'(gi));
  end

  // Strict mode only ever considers the next expected entry; any-order picks the lowest unmatched hit.
  assign w_cand     = STRICT_ORDER ? (w_addr_eq & w_is_exp) : (w_addr_eq & ~r_bitmap);
  assign w_sel      = w_cand & (~w_cand + NUM_CHECKS'(1));
  assign w_hit      = |w_sel;
  assign w_data_ok  = |(w_sel & w_data_eq);
  assign w_match    = wr.MemWrite & w_hit & w_data_ok;
  assign w_mismatch = wr.MemWrite & w_hit & ~w_data_ok;
  assign w_order    = STRICT_ORDER & wr.MemWrite & ~w_hit & (|(w_addr_eq & w_after));
  assign w_final    = w_match & (r_matched == MW'(NUM_CHECKS - 1));

  assign w_cycles_nxt = (&r_cycles) ? r_cycles : r_cycles + CYCLES_W'(1);
  assign w_timeout    = (w_cycles_nxt >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HOLD;
      r_fail_code <= NONE;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_matched   <= '0;
      r_cycles    <= '0;
      r_bitmap    <= '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_release) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          r_cycles <= w_cycles_nxt;
          if (w_match) begin
            r_matched <= r_matched + MW'(1);
            r_bitmap  <= r_bitmap | w_sel;
          end
          // A completing write wins over timeout; a bad write on the timeout edge reports its own code.
          if (w_final) begin
            r_state   <= PASS;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b1;
          end else if (w_mismatch || w_order || w_timeout) begin
            r_state   <= FAIL;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_fail    <= 1'b1;
            if (w_mismatch) begin
              r_fail_code <= MISMATCH;
            end else if (w_order) begin
              r_fail_code <= ORDER;
            end else begin
              r_fail_code <= TIMEOUT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign running   = r_running;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign matched   = r_matched;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: three checker configurations share one write port; each table row targets one of them.
module tb_mem_write_checker;
  import mem_write_checker_pkg::*;

  typedef struct packed {
    logic        dr;
    logic        run;
    logic        dn;
    logic        ps;
    logic        fl;
    logic [1:0]  code;
    logic [1:0]  mt;
    logic [31:0] cyc;
  } obs_t;

  typedef struct {
    int          sel;
    bit          rst;
    int          gap;
    bit          mw;
    logic [31:0] adr;
    logic [31:0] dat;
    obs_t        exp;
    string       nm;
  } vec_t;

  // Flag columns: {dut_reset, running, done, pass, fail}
  localparam logic [4:0] F_RST  = 5'b10000;
  localparam logic [4:0] F_RUN  = 5'b01000;
  localparam logic [4:0] F_PASS = 5'b00110;
  localparam logic [4:0] F_FAIL = 5'b00101;
  localparam int D1 = 0;
  localparam int DS = 1;
  localparam int DA = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) wif ();

  logic       u1_dr, u1_run, u1_dn, u1_ps, u1_fl, u1_mt;
  logic       us_dr, us_run, us_dn, us_ps, us_fl;
  logic       ua_dr, ua_run, ua_dn, ua_ps, ua_fl;
  fail_code_t u1_code, us_code, ua_code;
  logic [1:0] us_mt, ua_mt;
  logic [31:0] u1_cyc, us_cyc, ua_cyc;
  obs_t       obs [3];

  assign obs[0] = {u1_dr, u1_run, u1_dn, u1_ps, u1_fl, u1_code, 1'b0, u1_mt, u1_cyc};
  assign obs[1] = {us_dr, us_run, us_dn, us_ps, us_fl, us_code, us_mt, us_cyc};
  assign obs[2] = {ua_dr, ua_run, ua_dn, ua_ps, ua_fl, ua_code, ua_mt, ua_cyc};

  mem_write_checker #(.TIMEOUT_CYCLES(32'd50)) u_one (
    .clk(clk), .reset(reset), .check_addr(32'h64), .check_data(32'h19), .wr(wif),
    .dut_reset(u1_dr), .running(u1_run), .done(u1_dn), .pass(u1_ps), .fail(u1_fl),
    .fail_code(u1_code), .matched(u1_mt), .cycles(u1_cyc));

  mem_write_checker #(.NUM_CHECKS(3), .STRICT_ORDER(1'b1)) u_str (
    .clk(clk), .reset(reset), .check_addr({32'h68, 32'h64, 32'h60}), .check_data({32'd3, 32'd2, 32'd1}),
    .wr(wif), .dut_reset(us_dr), .running(us_run), .done(us_dn), .pass(us_ps), .fail(us_fl),
    .fail_code(us_code), .matched(us_mt), .cycles(us_cyc));

  mem_write_checker #(.NUM_CHECKS(3), .STRICT_ORDER(1'b0)) u_any (
    .clk(clk), .reset(reset), .check_addr({32'h68, 32'h64, 32'h60}), .check_data({32'd3, 32'd2, 32'd1}),
    .wr(wif), .dut_reset(ua_dr), .running(ua_run), .done(ua_dn), .pass(ua_ps), .fail(ua_fl),
    .fail_code(ua_code), .matched(ua_mt), .cycles(ua_cyc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input int sel, input bit rst, input int gap, input bit mw,
                              input logic [31:0] adr, input logic [31:0] dat, input logic [4:0] fl,
                              input fail_code_t code, input int mt, input int cyc, input string nm);
    vec_t v;
    v.sel = sel; v.rst = rst; v.gap = gap; v.mw = mw; v.adr = adr; v.dat = dat; v.nm = nm;
    v.exp = {fl, code, 2'(mt), 32'(cyc)};
    vecs.push_back(v);
  endfunction

  // Reset for two edges, then the two hold edges; the last row sees dut_reset fall and RUN begin.
  function automatic void add_start(input int sel, input string nm);
    add(sel, 1'b1, 1, 1'b0, 0, 0, F_RST, NONE, 0, 0, {nm, "_reset"});
    add(sel, 1'b0, 0, 1'b0, 0, 0, F_RST, NONE, 0, 0, {nm, "_hold"});
    add(sel, 1'b0, 0, 1'b0, 0, 0, F_RUN, NONE, 0, 0, {nm, "_release"});
  endfunction

  task automatic apply(input vec_t v);
    obs_t a;
    for (int k = 0; k < v.gap; k++) begin
      reset = v.rst; wif.MemWrite = 1'b0;
      @(negedge clk);
    end
    reset = v.rst; wif.MemWrite = v.mw; wif.DataAdr = v.adr; wif.WriteData = v.dat;
    @(negedge clk);
    wif.MemWrite = 1'b0;
    a = obs[v.sel];
    chk({v.nm, ".dut_reset"}, 32'(a.dr),   32'(v.exp.dr));
    chk({v.nm, ".running"},   32'(a.run),  32'(v.exp.run));
    chk({v.nm, ".done"},      32'(a.dn),   32'(v.exp.dn));
    chk({v.nm, ".pass"},      32'(a.ps),   32'(v.exp.ps));
    chk({v.nm, ".fail"},      32'(a.fl),   32'(v.exp.fl));
    chk({v.nm, ".fail_code"}, 32'(a.code), 32'(v.exp.code));
    chk({v.nm, ".matched"},   32'(a.mt),   32'(v.exp.mt));
    chk({v.nm, ".cycles"},    a.cyc,       v.exp.cyc);
  endtask

  initial begin
    int n;
    reset = 1'b1; wif.MemWrite = 1'b0; wif.DataAdr = '0; wif.WriteData = '0;

    // Single check 0x64:0x19, timeout 50
    add_start(D1, "s1");
    add(D1, 0, 28, 0, 0,     0,     F_RUN,  NONE,     0, 29, "s1_idle");
    add(D1, 0, 0,  1, 'h64, 'h19,  F_PASS, NONE,     1, 30, "s1_write30");
    add(D1, 0, 4,  0, 0,     0,     F_PASS, NONE,     1, 30, "s1_frozen");
    add(D1, 0, 0,  1, 'h64, 'h1A,  F_PASS, NONE,     1, 30, "s1_after_pass");
    add_start(D1, "s2");
    add(D1, 0, 4,  1, 'h64, 'h1A,  F_FAIL, MISMATCH, 0, 5,  "s2_baddata");
    add(D1, 0, 2,  1, 'h64, 'h19,  F_FAIL, MISMATCH, 0, 5,  "s2_sticky");
    add_start(D1, "s3");
    add(D1, 0, 48, 0, 0,     0,     F_RUN,  NONE,     0, 49, "s3_cyc49");
    add(D1, 0, 0,  0, 0,     0,     F_FAIL, TIMEOUT,  0, 50, "s3_timeout");
    add(D1, 0, 3,  0, 0,     0,     F_FAIL, TIMEOUT,  0, 50, "s3_frozen");
    add_start(D1, "s4");
    add(D1, 0, 49, 1, 'h64, 'h19,  F_PASS, NONE,     1, 50, "s4_pass_on_to");
    add_start(D1, "s5");
    add(D1, 0, 49, 1, 'h64, 'h1A,  F_FAIL, MISMATCH, 0, 50, "s5_mm_on_to");
    // Strict, table {0x60:1, 0x64:2, 0x68:3}
    add_start(DS, "s6");
    add(DS, 0, 2,  1, 'h68, 3,     F_FAIL, ORDER,    0, 3,  "s6_order_first");
    add_start(DS, "s7");
    add(DS, 0, 0,  1, 'h60, 1,     F_RUN,  NONE,     1, 1,  "s7_w60");
    add(DS, 0, 0,  1, 'h80, 5,     F_RUN,  NONE,     1, 2,  "s7_unrelated");
    add(DS, 0, 0,  1, 'h60, 7,     F_RUN,  NONE,     1, 3,  "s7_old_addr");
    add(DS, 0, 0,  1, 'h64, 2,     F_RUN,  NONE,     2, 4,  "s7_w64");
    add(DS, 0, 3,  1, 'h68, 3,     F_PASS, NONE,     3, 8,  "s7_w68");
    add_start(DS, "s8");
    add(DS, 0, 0,  1, 'h60, 1,     F_RUN,  NONE,     1, 1,  "s8_w60");
    add(DS, 0, 0,  1, 'h68, 3,     F_FAIL, ORDER,    1, 2,  "s8_skip");
    add_start(DS, "s9");
    add(DS, 0, 0,  1, 'h60, 1,     F_RUN,  NONE,     1, 1,  "s9_w60");
    add(DS, 0, 0,  1, 'h64, 5,     F_FAIL, MISMATCH, 1, 2,  "s9_bad64");
    // Any order, same table
    add_start(DA, "s10");
    add(DA, 0, 0,  1, 'h68, 3,     F_RUN,  NONE,     1, 1,  "s10_w68");
    add(DA, 0, 0,  1, 'h68, 9,     F_RUN,  NONE,     1, 2,  "s10_done_addr");
    add(DA, 0, 0,  1, 'h60, 1,     F_RUN,  NONE,     2, 3,  "s10_w60");
    add(DA, 0, 0,  1, 'h60, 1,     F_RUN,  NONE,     2, 4,  "s10_dup60");
    add(DA, 0, 0,  1, 'h64, 2,     F_PASS, NONE,     3, 5,  "s10_w64");
    add_start(DA, "s11");
    add(DA, 0, 0,  1, 'h64, 2,     F_RUN,  NONE,     1, 1,  "s11_w64");
    add(DA, 0, 0,  1, 'h68, 9,     F_FAIL, MISMATCH, 1, 2,  "s11_bad68");
    // Reset mid-RUN, then a clean pass
    add_start(DS, "s12");
    add(DS, 0, 0,  1, 'h60, 1,     F_RUN,  NONE,     1, 1,  "s12_w60");
    add(DS, 1, 0,  0, 0,     0,     F_RST,  NONE,     0, 0,  "s12_midreset");
    add(DS, 0, 0,  0, 0,     0,     F_RST,  NONE,     0, 0,  "s12_hold");
    add(DS, 0, 0,  0, 0,     0,     F_RUN,  NONE,     0, 0,  "s12_release");
    add(DS, 0, 0,  1, 'h60, 1,     F_RUN,  NONE,     1, 1,  "s12_r60");
    add(DS, 0, 0,  1, 'h64, 2,     F_RUN,  NONE,     2, 2,  "s12_r64");
    add(DS, 0, 0,  1, 'h68, 3,     F_PASS, NONE,     3, 3,  "s12_r68");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Edge-by-edge release and timeout on the single-check instance, with bounded waits
    reset = 1'b1; wif.MemWrite = 1'b0;
    repeat (3) @(negedge clk);
    chk("hs_reset_dut_reset", 32'(obs[0].dr), 32'd1);
    reset = 1'b0;
    n = 0;
    while (obs[0].dr === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hs_release_edges", n, 32'd2);
    chk("hs_running_at_release", 32'(obs[0].run), 32'd1);
    n = 0;
    while (obs[0].dn !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hs_done_edges", n, 32'd50);
    chk("hs_timeout_code", 32'(obs[0].code), 32'(TIMEOUT));
    chk("hs_timeout_cycles", obs[0].cyc, 32'd50);
    chk("hs_dut_reset_stays_low", 32'(obs[0].dr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised end-of-test checker for the multicycle RISC-V core benches. It sequences the core's reset for a configurable number of cycles, then watches the data-memory write port against a table of expected (address, data) pairs. It reports a sticky pass/fail verdict with a failure code, or a timeout. It sits beside `top` in every bench and replaces hard-coded single-value "Simulation succeeded" checks.

## Interface
Parameters:
- `RESET_CYCLES`, default 2: cycles `dut_reset` stays high after `reset` falls; must be ≥1.
- `TIMEOUT_CYCLES`, default 10000: RUN cycles allowed before a TIMEOUT fail.
- `NUM_CHECKS`, default 1: number of expected writes; must be ≥1.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STRICT_ORDER`, default 1: 1 means checks must complete in index order; 0 means any order.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `check_addr`  in  NUM_CHECKS*ADDR_W  expected addresses, flattened; entry i is at bits [i*ADDR_W +: ADDR_W]; static during a run.
- `check_data`  in  NUM_CHECKS*DATA_W  expected data, same packing.
- `MemWrite`  in  1  core write strobe.
- `DataAdr`  in  ADDR_W  core write address.
- `WriteData`  in  DATA_W  core write data.
- `dut_reset`  out  1  reset to the core.
- `running`  out  1  high in RUN.
- `done`  out  1  high in PASS or FAIL.
- `pass`  out  1  sticky pass.
- `fail`  out  1  sticky fail.
- `fail_code`  out  2  0 NONE, 1 MISMATCH, 2 ORDER, 3 TIMEOUT.
- `matched`  out  $clog2(NUM_CHECKS+1)  number of completed checks.
- `cycles`  out  32  RUN cycle count; saturates at 2^32-1.

## Operation
- States: HOLD, RUN, PASS, FAIL.
- `reset`=1 forces HOLD. Reset values:
  - `dut_reset`=1
  - `running`, `done`, `pass`, `fail` = 0
  - `fail_code`=0, `matched`=0, `cycles`=0
  - hold counter and match bitmap cleared.
- HOLD: the hold counter increments each cycle with `reset`=0. When it reaches RESET_CYCLES, go to RUN and drop `dut_reset`.
- RUN: `cycles` increments every cycle. The write port is sampled only when `MemWrite`=1.
- Strict mode (STRICT_ORDER=1), expected index e = `matched`:
  - `DataAdr`==addr[e] and `WriteData`==data[e]: `matched`++.
  - `DataAdr`==addr[e] and data differs: go to FAIL, code MISMATCH.
  - `DataAdr` equals any unmatched addr[j] with j>e (and not addr[e]): go to FAIL, code ORDER.
  - Any other address, including already-matched addresses: ignored.
- Any-order mode (STRICT_ORDER=0): compare against the lowest-index unmatched entry whose address equals `DataAdr`.
  - Data equal: set its bitmap bit and increment `matched`.
  - Data differs: go to FAIL, code MISMATCH.
  - No unmatched entry with that address: ignored. ORDER is never raised.
- When `matched` reaches NUM_CHECKS, go to PASS.
- When `cycles` reaches TIMEOUT_CYCLES while in RUN, go to FAIL, code TIMEOUT.
- Same-cycle conflicts: a final matching write on the timeout cycle gives PASS. A MISMATCH or ORDER on the timeout cycle reports that code, not TIMEOUT.
- PASS/FAIL: terminal until `reset`.
  - `dut_reset` stays 0; the core keeps running.
  - `MemWrite` is ignored; `cycles` freezes.
- `reset` asserted in any state, including mid-RUN, returns to HOLD with all reset values on the next edge.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `dut_reset` is high on every edge while `reset`=1, plus exactly RESET_CYCLES further edges after `reset` is first sampled low.
- The first core cycle counted in `cycles` is the edge after `dut_reset` falls.
- Verdict latency is one edge. A write sampled at edge k updates `matched`, `pass` or `fail` at the output after edge k.
- Simultaneous writes: at most one write per cycle by construction (a single port).
- `cycles` width is independent of TIMEOUT_CYCLES; TIMEOUT_CYCLES must be < 2^32.

## Structure
- Package `mem_write_checker_pkg`:
  - `checker_state_t` enum (HOLD, RUN, PASS, FAIL)
  - `fail_code_t` enum (NONE, MISMATCH, ORDER, TIMEOUT)
  - the width constant for `cycles`.
- Sub-module `reset_sequencer`: the HOLD counter and the `dut_reset` register. It takes `clk`, `reset` and RESET_CYCLES and outputs `dut_reset` plus a one-cycle `release` pulse.
- The checker FSM, bitmap and comparators live in `mem_write_checker`. The comparators are a generate loop over NUM_CHECKS.

## Test plan
- Defaults, one check at addr 0x64, data 0x19. Hold `reset` for 2 edges, then write (0x64, 0x19) at RUN cycle 30 -> `dut_reset` low exactly 2 edges after `reset` falls; `pass`=1 one edge after the write; `matched`=1; `cycles`=30 frozen.
- Same check, write (0x64, 0x1A) -> `fail`=1, `fail_code`=MISMATCH. A later (0x64, 0x19) does not clear the fail.
- NUM_CHECKS=3, STRICT_ORDER=1, table {0x60:1, 0x64:2, 0x68:3}:
  - write 0x68 first -> ORDER.
  - write in order with an unrelated 0x80 write in between -> PASS; `matched`=3.
- Same table with STRICT_ORDER=0, writes in order 0x68, 0x60, 0x64 -> PASS; a duplicate 0x60 write between them is ignored.
- TIMEOUT_CYCLES=50, no writes -> `fail_code`=TIMEOUT after RUN cycle 50. Repeat with the final matching write on cycle 50 -> PASS.
- Assert `reset` mid-RUN after `matched`=1 -> all outputs return to reset values. A full passing sequence then completes normally.
